// File: rtl/ps2_tx_sched_if.sv
// Request, accept and byte-transmitter handshake bundle for ps2_tx_sched.
// master drives requests and transmitter status; slave is the scheduler.
interface ps2_tx_sched_if;
  logic       resp_valid;
  logic [7:0] resp_byte;
  logic       resp_accept;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_accept;
  logic       tx_start;
  logic [7:0] tx_buffer;
  logic       tx_ready;
  logic       tx_finish;
  logic       tx_abort;
  logic       busy;
  logic       drop;

  modport master (
    output resp_valid, resp_byte, key_valid, key_code, key_ext, key_break,
           tx_ready, tx_finish, tx_abort,
    input  resp_accept, key_accept, tx_start, tx_buffer, busy, drop
  );

  modport slave (
    input  resp_valid, resp_byte, key_valid, key_code, key_ext, key_break,
           tx_ready, tx_finish, tx_abort,
    output resp_accept, key_accept, tx_start, tx_buffer, busy, drop
  );
endinterface

// File: rtl/ps2_tx_sched.sv
// PS/2 output byte scheduler: response > key priority, E0/F0 expansion, retry/drop; tx_start GAP_CYCLES+1 after accept.
// Accepts only in IDLE (no preemption); a byte waits in GAP while tx_ready is low.
module ps2_tx_sched #(
  parameter int GAP_CYCLES = 16,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 4096
) (
  input  logic          clock,
  input  logic          reset_n,
  ps2_tx_sched_if.slave bus
);
  localparam int GAP_W    = $clog2(GAP_CYCLES) + 1;
  localparam int TMO_W    = $clog2(TIMEOUT) + 1;
  localparam int RETRY_W0 = $clog2(MAX_RETRY) + 1;
  localparam int RETRY_W  = (RETRY_W0 < 2) ? 2 : RETRY_W0;

  typedef enum logic [1:0] {IDLE, GAP, SEND, WAIT} state_t;

  state_t              state, state_nxt;
  logic [2:0][7:0]     seq_q, seq_nxt;
  logic [1:0]          len_q, len_nxt;
  logic [1:0]          idx_q, idx_nxt;
  logic [RETRY_W-1:0]  retry_q, retry_nxt;
  logic [GAP_W-1:0]    gap_q, gap_nxt;
  logic [TMO_W-1:0]    tmo_q, tmo_nxt;
  logic [7:0]          buf_q, buf_nxt;
  logic                drop_q, drop_nxt;
  logic                resp_take;
  logic                key_take;

  assign resp_take = reset_n && (state == IDLE) && bus.resp_valid;
  assign key_take  = reset_n && (state == IDLE) && bus.key_valid && !bus.resp_valid;

  assign bus.resp_accept = resp_take;
  assign bus.key_accept  = key_take;
  assign bus.tx_start    = (state == SEND);
  assign bus.tx_buffer   = buf_q;
  assign bus.busy        = (state != IDLE);
  assign bus.drop        = drop_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= IDLE;
      seq_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      retry_q <= '0;
      gap_q   <= '0;
      tmo_q   <= '0;
      buf_q   <= 8'h00;
      drop_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      seq_q   <= seq_nxt;
      len_q   <= len_nxt;
      idx_q   <= idx_nxt;
      retry_q <= retry_nxt;
      gap_q   <= gap_nxt;
      tmo_q   <= tmo_nxt;
      buf_q   <= buf_nxt;
      drop_q  <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    seq_nxt   = seq_q;
    len_nxt   = len_q;
    idx_nxt   = idx_q;
    retry_nxt = retry_q;
    gap_nxt   = gap_q;
    tmo_nxt   = tmo_q;
    buf_nxt   = buf_q;
    drop_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (resp_take || key_take) begin
          seq_nxt   = '0;
          idx_nxt   = '0;
          retry_nxt = '0;
          gap_nxt   = GAP_W'(GAP_CYCLES);
          state_nxt = GAP;
          if (resp_take) begin
            seq_nxt[0] = bus.resp_byte;
            len_nxt    = 2'd1;
          end else begin
            // Set-2 order: E0 first, then F0, then the code byte
            case ({bus.key_ext, bus.key_break})
              2'b11: begin
                seq_nxt[0] = 8'hE0;
                seq_nxt[1] = 8'hF0;
                seq_nxt[2] = bus.key_code;
                len_nxt    = 2'd3;
              end
              2'b10: begin
                seq_nxt[0] = 8'hE0;
                seq_nxt[1] = bus.key_code;
                len_nxt    = 2'd2;
              end
              2'b01: begin
                seq_nxt[0] = 8'hF0;
                seq_nxt[1] = bus.key_code;
                len_nxt    = 2'd2;
              end
              default: begin
                seq_nxt[0] = bus.key_code;
                len_nxt    = 2'd1;
              end
            endcase
          end
        end
      end
      GAP: begin
        if (gap_q != '0) begin
          gap_nxt = gap_q - GAP_W'(1);
        end else if (bus.tx_ready) begin
          buf_nxt   = seq_q[idx_q];
          state_nxt = SEND;
        end
      end
      SEND: begin
        tmo_nxt   = TMO_W'(TIMEOUT);
        state_nxt = WAIT;
      end
      WAIT: begin
        // abort outranks a simultaneous finish; timeout behaves as an abort
        if (bus.tx_abort || (tmo_q == '0)) begin
          if (retry_q == RETRY_W'(MAX_RETRY)) begin
            drop_nxt  = 1'b1;
            state_nxt = IDLE;
          end else begin
            retry_nxt = retry_q + RETRY_W'(1);
            gap_nxt   = GAP_W'(GAP_CYCLES);
            state_nxt = GAP;
          end
        end else if (bus.tx_finish) begin
          if (idx_q == (len_q - 2'd1)) begin
            state_nxt = IDLE;
          end else begin
            idx_nxt   = idx_q + 2'd1;
            retry_nxt = '0;
            gap_nxt   = GAP_W'(GAP_CYCLES);
            state_nxt = GAP;
          end
        end else begin
          tmo_nxt = tmo_q - TMO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_ps2_tx_sched.sv
// Directed bench for ps2_tx_sched: queue-level scheduling model checked every cycle,
// plus literal expectations on byte order, latency and drop count.
module tb_ps2_tx_sched;
  localparam int GAP  = 16;
  localparam int MAXR = 3;
  localparam int TMO  = 64;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  ps2_tx_sched_if bus ();

  ps2_tx_sched #(.GAP_CYCLES(GAP), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;
  int drop_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: pending bytes of the current sequence plus the timing rules.
  bit         m_busy     = 1'b0;
  bit         m_inflight = 1'b0;
  int         m_next     = 0;
  int         m_sedge    = -1;
  int         m_retry    = 0;
  int         m_drop_edge = -1;
  logic [7:0] m_cur      = 8'h00;
  logic [7:0] m_q[$];

  task automatic m_begin();
    m_busy     = 1'b1;
    m_inflight = 1'b0;
    m_retry    = 0;
    m_next     = cyc + GAP + 1;
  endtask

  always @(posedge clock) begin
    cyc++;
    if (!reset_n) begin
      m_busy = 1'b0; m_inflight = 1'b0; m_drop_edge = -1; m_q.delete();
    end else if (!m_busy) begin
      if (bus.resp_valid) begin
        m_q.delete(); m_q.push_back(bus.resp_byte); m_begin();
      end else if (bus.key_valid) begin
        m_q.delete();
        if (bus.key_ext)   m_q.push_back(8'hE0);
        if (bus.key_break) m_q.push_back(8'hF0);
        m_q.push_back(bus.key_code);
        m_begin();
      end
    end else if (!m_inflight) begin
      if (cyc >= m_next && bus.tx_ready) begin
        m_inflight = 1'b1; m_sedge = cyc; m_cur = m_q[0];
      end
    end else if (cyc >= m_sedge + 2) begin
      if (bus.tx_abort || cyc == m_sedge + TMO + 2) begin
        m_inflight = 1'b0;
        if (m_retry == MAXR) begin
          m_busy = 1'b0; m_drop_edge = cyc;
        end else begin
          m_retry++; m_next = cyc + GAP + 1;
        end
      end else if (bus.tx_finish) begin
        m_inflight = 1'b0;
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_busy = 1'b0;
        else begin m_retry = 0; m_next = cyc + GAP + 1; end
      end
    end
  end

  always @(negedge clock) begin
    #2;
    if (chk_en) begin
      chk("resp_accept", bus.resp_accept, reset_n && !m_busy && bus.resp_valid);
      chk("key_accept", bus.key_accept, reset_n && !m_busy && bus.key_valid && !bus.resp_valid);
      chk("tx_start", bus.tx_start, m_inflight && cyc == m_sedge);
      chk("busy", bus.busy, m_busy);
      chk("drop", bus.drop, cyc == m_drop_edge);
      if (m_inflight) chk("tx_buffer", bus.tx_buffer, m_cur);
      if (bus.drop === 1'b1) drop_cnt++;
    end
  end

  // Transmitter stand-in: per-byte scripted reply (0 finish, 1 abort, 2 silent, 3 abort+finish).
  typedef struct packed {logic [1:0] kind; logic [7:0] dly;} act_t;
  act_t       acts[$];
  logic [7:0] start_log[$];
  int         start_cyc[$];

  initial begin
    act_t a;
    bus.tx_finish = 1'b0;
    bus.tx_abort  = 1'b0;
    forever begin
      @(negedge clock);
      if (bus.tx_start === 1'b1) begin
        start_log.push_back(bus.tx_buffer);
        start_cyc.push_back(cyc);
        if (acts.size() > 0) a = acts.pop_front();
        else begin a.kind = 2'd0; a.dly = 8'd10; end
        if (a.kind != 2'd2) begin
          repeat (int'(a.dly)) @(negedge clock);
          bus.tx_finish = (a.kind == 2'd0) || (a.kind == 2'd3);
          bus.tx_abort  = (a.kind == 2'd1) || (a.kind == 2'd3);
          @(negedge clock);
          bus.tx_finish = 1'b0;
          bus.tx_abort  = 1'b0;
        end
      end
    end
  end

  task automatic push_act(input logic [1:0] kind, input int n);
    act_t a;
    a.kind = kind; a.dly = 8'd10;
    for (int i = 0; i < n; i++) acts.push_back(a);
  endtask

  task automatic request(input bit is_resp, input logic [7:0] b, input bit ext, input bit brk,
                         output int acc_edge, output int tries);
    bit got;
    got = 1'b0; tries = 0;
    @(negedge clock);
    if (is_resp) begin
      bus.resp_valid = 1'b1; bus.resp_byte = b;
    end else begin
      bus.key_valid = 1'b1; bus.key_code = b; bus.key_ext = ext; bus.key_break = brk;
    end
    while (!got && tries < 3000) begin
      #1;
      tries++;
      got = is_resp ? bus.resp_accept : bus.key_accept;
      if (!got) @(negedge clock);
    end
    chk(is_resp ? "resp_accept_wait" : "key_accept_wait", got, 1);
    acc_edge = cyc + 1;
    @(negedge clock);
    bus.resp_valid = 1'b0; bus.key_valid = 1'b0; bus.key_ext = 1'b0; bus.key_break = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clock); #1; n++;
    end while (bus.busy !== 1'b0 && n < 3000);
    chk({name, "_idle"}, bus.busy, 0);
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_log(input string name, input logic [7:0] exp_q[$]);
    chk({name, "_count"}, start_log.size(), exp_q.size());
    foreach (exp_q[i]) if (i < start_log.size()) chk({name, "_byte"}, start_log[i], exp_q[i]);
  endtask

  task automatic clear_logs();
    start_log.delete(); start_cyc.delete(); drop_cnt = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  logic [7:0] e[$];
  int acc, acc_k, tries, n;

  initial begin
    bus.resp_valid = 1'b1; bus.resp_byte = 8'hFA;
    bus.key_valid = 1'b1; bus.key_code = 8'h1C; bus.key_ext = 1'b0; bus.key_break = 1'b0;
    bus.tx_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_en = 1'b1;
    @(negedge clock); #1;
    chk("rst_resp_accept", bus.resp_accept, 0);
    chk("rst_key_accept", bus.key_accept, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_buffer", bus.tx_buffer, 8'h00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_drop", bus.drop, 0);
    @(negedge clock);
    bus.resp_valid = 1'b0; bus.key_valid = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    // single plain key
    clear_logs();
    request(1'b0, 8'h1C, 1'b0, 1'b0, acc, tries);
    wait_idle("t1");
    e = '{8'h1C}; chk_log("t1", e);
    if (start_cyc.size() > 0) chk("t1_latency", start_cyc[0] - acc, 17);
    chk("t1_drops", drop_cnt, 0);

    // extended break: E0 F0 6B
    clear_logs();
    request(1'b0, 8'h6B, 1'b1, 1'b1, acc, tries);
    wait_idle("t2");
    e = '{8'hE0, 8'hF0, 8'h6B}; chk_log("t2", e);
    if (start_cyc.size() == 3) begin
      chk("t2_gap1", start_cyc[1] - start_cyc[0], 28);
      chk("t2_gap2", start_cyc[2] - start_cyc[1], 28);
    end

    // response and key in the same cycle
    clear_logs();
    @(negedge clock);
    bus.resp_valid = 1'b1; bus.resp_byte = 8'hFA;
    bus.key_valid = 1'b1; bus.key_code = 8'h1C;
    #1;
    chk("t3_resp_accept", bus.resp_accept, 1);
    chk("t3_key_accept", bus.key_accept, 0);
    @(negedge clock);
    bus.resp_valid = 1'b0;
    n = 0;
    do begin #1; n++; if (bus.key_accept !== 1'b1) @(negedge clock); end
    while (bus.key_accept !== 1'b1 && n < 3000);
    chk("t3_key_accept_wait", bus.key_accept, 1);
    acc_k = cyc + 1;
    @(negedge clock);
    bus.key_valid = 1'b0;
    wait_idle("t3");
    e = '{8'hFA, 8'h1C}; chk_log("t3", e);
    if (start_cyc.size() > 0) chk("t3_key_after_fa", acc_k - start_cyc[0], 12);

    // two aborts on F0 (second one coincides with finish), then success
    clear_logs();
    push_act(2'd0, 1); push_act(2'd1, 1); push_act(2'd3, 1); push_act(2'd0, 2);
    request(1'b0, 8'h6B, 1'b1, 1'b1, acc, tries);
    wait_idle("t4");
    e = '{8'hE0, 8'hF0, 8'hF0, 8'hF0, 8'h6B}; chk_log("t4", e);
    chk("t4_drops", drop_cnt, 0);

    // four aborts on one byte -> drop
    clear_logs();
    push_act(2'd1, 4);
    request(1'b0, 8'h29, 1'b0, 1'b0, acc, tries);
    wait_idle("t5a");
    e = '{8'h29, 8'h29, 8'h29, 8'h29}; chk_log("t5a", e);
    chk("t5a_drops", drop_cnt, 1);

    // same via timeouts
    clear_logs();
    push_act(2'd2, 4);
    request(1'b0, 8'h29, 1'b0, 1'b0, acc, tries);
    wait_idle("t5b");
    e = '{8'h29, 8'h29, 8'h29, 8'h29}; chk_log("t5b", e);
    chk("t5b_drops", drop_cnt, 1);
    if (start_cyc.size() == 4) chk("t5b_retry_spacing", start_cyc[1] - start_cyc[0], 83);

    // reset during the WAIT of byte 2
    clear_logs();
    push_act(2'd0, 1); push_act(2'd2, 1);
    request(1'b0, 8'h12, 1'b1, 1'b0, acc, tries);
    n = 0;
    while (start_log.size() < 2 && n < 3000) begin @(negedge clock); n++; end
    chk("t6_second_start", start_log.size(), 2);
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("t6_tx_start", bus.tx_start, 0);
    chk("t6_busy", bus.busy, 0);
    chk("t6_drop", bus.drop, 0);
    request(1'b0, 8'h1C, 1'b0, 1'b0, acc, tries);
    chk("t6_immediate_accept", tries, 1);
    wait_idle("t6");
    e = '{8'hE0, 8'h12, 8'h1C}; chk_log("t6", e);
    chk("t6_drops", drop_cnt, 0);

    // transmitter not ready when the gap expires
    clear_logs();
    bus.tx_ready = 1'b0;
    request(1'b0, 8'h5A, 1'b0, 1'b0, acc, tries);
    repeat (24) @(negedge clock);
    bus.tx_ready = 1'b1;
    wait_idle("t7");
    e = '{8'h5A}; chk_log("t7", e);
    if (start_cyc.size() > 0) chk("t7_ready_latency", start_cyc[0] - acc, 25);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ps2_tx_sched.md
Name: ps2_tx_sched

Overview:
- Sequences keyboard output bytes into the PS/2 byte transmitter (start/ready/finish/abort handshake).
- Arbitrates between two requesters:
  - host-command responder: single bytes such as 0xFA ACK or 0xAA BAT; highest priority.
  - key event source: scan codes, expanded to 1–3 byte Set-2 sequences with E0/F0 prefixes.
- Retransmits bytes the host aborts, enforces an inter-byte gap, and drops a sequence after repeated failures.

Parameters:
- GAP_CYCLES, 16: idle clock cycles required before every tx_start.
- MAX_RETRY, 3: aborts/timeouts tolerated per byte; the next one drops the sequence.
- TIMEOUT, 4096: clock cycles allowed in WAIT before the byte counts as aborted.

Ports:
- clock  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- resp_valid  in  1  response byte pending
- resp_byte  in  8  response byte
- resp_accept  out  1  response taken this cycle
- key_valid  in  1  key event pending
- key_code  in  8  Set-2 code byte
- key_ext  in  1  extended key; prepend E0
- key_break  in  1  key release; prepend F0 after any E0
- key_accept  out  1  key event taken this cycle
- tx_start  out  1  one-cycle start pulse to transmitter
- tx_buffer  out  8  byte to transmit
- tx_ready  in  1  transmitter idle
- tx_finish  in  1  byte completed
- tx_abort  in  1  host inhibited transfer
- busy  out  1  sequence in progress (state != IDLE)
- drop  out  1  one-cycle pulse: sequence abandoned

Behaviour:
- Reset (reset_n low at posedge clock):
  - state IDLE; tx_start=0, tx_buffer=8'h00, drop=0; busy=0.
  - idx=0, retry=0, gap counter=0; sequence registers cleared.
  - resp_accept and key_accept are forced 0 while reset_n is low.
  - Reset mid-transfer abandons the sequence with no drop pulse.
- Accepts are combinational and only asserted in IDLE:
  - resp_accept = IDLE & resp_valid.
  - key_accept = IDLE & key_valid & !resp_valid.
  - A request is transferred on a posedge where valid & accept.
- Sequence build on accept, into seq[0..2] with len 1..3:
  - response: [resp_byte].
  - key: [E0 if key_ext] [F0 if key_break] key_code, in that order.
  - Example: ext+break 0x6B gives E0,F0,6B (len 3).
- States:
  - IDLE: on accept, capture the sequence, set idx=0, retry=0, gap counter=GAP_CYCLES, go to GAP.
  - GAP: decrement the counter each cycle. When the counter is 0 and tx_ready=1, go to SEND. If tx_ready=0, wait in GAP with the counter held at 0.
  - SEND: tx_start=1 for exactly this cycle; tx_buffer=seq[idx]. Go to WAIT and load the timeout counter with TIMEOUT.
  - WAIT: tx_buffer must stay stable, because the transmitter samples it throughout the byte. Priority order:
    - tx_abort, or timeout counter reaching 0: retry event.
    - tx_finish: if idx==len-1, go to IDLE; otherwise idx++, retry=0, counter=GAP_CYCLES, go to GAP.
  - Retry event: if retry==MAX_RETRY, pulse drop and go to IDLE. Otherwise retry++, keep idx (resend the same byte), counter=GAP_CYCLES, go to GAP.
- tx_abort and tx_finish in the same cycle: abort wins.
- tx_finish or tx_abort outside WAIT is ignored.
- No preemption: a pending response waits until the current key sequence returns to IDLE.
- Back-to-back sequences: IDLE lasts at least 1 cycle between sequences. Latency from accept to tx_start is GAP_CYCLES+1 cycles when tx_ready=1.
- Counter widths: use clog2(max value)+1. retry is a 2-bit minimum and must not wrap before the MAX_RETRY compare.

Test Plan:
- Key 0x1C (ext=0, brk=0), tx_ready=1, finish 10 cycles after start -> one tx_start with tx_buffer=1C at accept+17 cycles; busy falls after finish; drop=0.
- Key 0x6B with ext=1, brk=1 -> three tx_start pulses carrying E0, F0, 6B in order, each ≥16 cycles after the previous finish; tx_buffer stable during each WAIT.
- resp_valid(0xFA) and key_valid in the same IDLE cycle -> resp_accept=1, key_accept=0; FA sent first; key accepted on the first IDLE cycle after FA finishes.
- Abort on the F0 byte of E0,F0,6B, twice, then finish -> F0 sent 3 times; E0 is not resent; 6B follows; drop=0.
- Abort 4 consecutive times on a single byte 0x29 -> 4 tx_start pulses, then a drop pulse of 1 cycle and IDLE. With TIMEOUT=64 and no finish/abort -> identical result via timeouts.
- reset_n low for 1 cycle during the WAIT of byte 2 -> next cycle IDLE, tx_start=0, busy=0, drop=0, no further bytes; a new key is accepted immediately after.
